// File: rtl/udp_seq_bank.sv
// ---------------------------------------------------------------------------
// udp_seq_bank
//   A bank of CHANNELS independent table-driven sequential primitives. Each
//   channel replaces a single-output sequential UDP with plain flops:
//     1. The raw input a[i] passes through a debounce filter. A change is
//        accepted into af only after FILTER consecutive samples differ from
//        the current af.
//     2. af_prev holds af from the previous edge, so the pair (af_prev, af)
//        carries the edge and level history of the filtered input.
//     3. The next state is looked up in the 8-entry TABLE, indexed by
//        {q, af_prev, af}. A load of all channels takes priority over the
//        per-channel enable.
//
// Parameters
//   CHANNELS  number of independent channels (>=1)
//   FILTER    consecutive differing samples needed to accept a change (>=1)
//   TABLE     next-state table, bit index = {q, af_prev, af}
//   INIT      reset value of every channel state q
//
// Ports
//   clk       in   1         clock, rising edge
//   rst       in   1         asynchronous reset, active high
//   en        in   CHANNELS  per-channel state-update enable
//   a         in   CHANNELS  raw primitive inputs
//   load      in   1         force the state of all channels to load_val
//   load_val  in   CHANNELS  value forced while load=1
//   o         out  CHANNELS  primitive outputs (the state q)
//   changed   out  CHANNELS  pulse, high in the first cycle o holds a new value
//
// Handshake: none. Every input is sampled at each rising clk edge. Every
// output is a registered value, valid for the whole cycle after that edge.
// ---------------------------------------------------------------------------
module udp_seq_bank #(
  parameter int         CHANNELS = 2,
  parameter int         FILTER   = 1,
  parameter logic [7:0] TABLE    = 8'b01010101,
  parameter logic       INIT     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] a,
  input  logic                load,
  input  logic [CHANNELS-1:0] load_val,
  output logic [CHANNELS-1:0] o,
  output logic [CHANNELS-1:0] changed
);

  localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER - 1);

  logic [CHANNELS-1:0] af_q,      af_d;
  logic [CHANNELS-1:0] af_prev_q, af_prev_d;
  logic [CHANNELS-1:0] q_q,       q_d;
  logic [CHANNELS-1:0] changed_q, changed_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Debounce filter. If a sample matches af, any partial count is dropped,
  // so a pulse shorter than FILTER samples never reaches af. With FILTER=1,
  // CNT_MAX is 0 and af becomes a plain one-cycle register of a.
  always_comb begin
    af_d = af_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (a[i] == af_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        af_d[i]  = a[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // af_prev keeps tracking af even when a channel is disabled or loaded.
  // This way, re-enabling a channel on a stable input sees a level and not
  // a stale edge.
  always_comb begin
    af_prev_d = af_q;
  end

  // State update. The table is indexed with the registered filtered
  // history, so a change in a reaches o one edge after it reaches af.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load) begin
        q_d[i] = load_val[i];
      end else if (en[i]) begin
        q_d[i] = TABLE[{q_q[i], af_prev_q[i], af_q[i]}];
      end else begin
        q_d[i] = q_q[i];
      end
    end
  end

  // changed is registered alongside q. It is high exactly in the cycle
  // where o first shows a new value.
  always_comb begin
    changed_d = q_d ^ q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q      <= '0;
      af_prev_q <= '0;
      q_q       <= {CHANNELS{INIT}};
      changed_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      af_q      <= af_d;
      af_prev_q <= af_prev_d;
      q_q       <= q_d;
      changed_q <= changed_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o       = q_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_udp_seq_bank.sv
// ---------------------------------------------------------------------------
// tb_udp_seq_bank
//   Bench for udp_seq_bank. It uses three instances:
//     dut_a : default parameters (registered inverter, FILTER=1, INIT=0)
//     dut_t : TABLE=8'hD2, which toggles q on a rising filtered input
//     dut_f : FILTER=4, INIT=1, default inverter table
//   Inputs are driven 1 time unit after a rising edge. Outputs are sampled
//   at that same point, before the new drive.
// ---------------------------------------------------------------------------
module tb_udp_seq_bank;

  logic       clk;
  logic       rst_a, rst_t, rst_f;
  logic [1:0] en_a, a_a, lv_a, o_a, ch_a;
  logic [1:0] en_t, a_t, lv_t, o_t, ch_t;
  logic [1:0] en_f, a_f, lv_f, o_f, ch_f;
  logic       load_a, load_t, load_f;

  int total;
  int bad;

  udp_seq_bank #(.CHANNELS(2)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .a(a_a), .load(load_a),
    .load_val(lv_a), .o(o_a), .changed(ch_a)
  );

  udp_seq_bank #(.CHANNELS(2), .TABLE(8'hD2)) dut_t (
    .clk(clk), .rst(rst_t), .en(en_t), .a(a_t), .load(load_t),
    .load_val(lv_t), .o(o_t), .changed(ch_t)
  );

  udp_seq_bank #(.CHANNELS(2), .FILTER(4), .INIT(1'b1)) dut_f (
    .clk(clk), .rst(rst_f), .en(en_f), .a(a_f), .load(load_f),
    .load_val(lv_f), .o(o_f), .changed(ch_f)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_t = 1'b1; rst_f = 1'b1;
    #1;
    total++; if (o_a !== 2'b00) begin bad++; $display("FAIL reset_o_a: got %b want 00", o_a); end
    total++; if (ch_a !== 2'b00) begin bad++; $display("FAIL reset_ch_a: got %b want 00", ch_a); end
    total++; if (o_t !== 2'b00) begin bad++; $display("FAIL reset_o_t: got %b want 00", o_t); end
    total++; if (o_f !== 2'b11) begin bad++; $display("FAIL reset_o_f: got %b want 11", o_f); end
    total++; if (ch_f !== 2'b00) begin bad++; $display("FAIL reset_ch_f: got %b want 00", ch_f); end
    tick();
    rst_a = 1'b0; rst_t = 1'b0; rst_f = 1'b0;
  endtask

  // a[0]=cyc[0], a[1]=~cyc[0]; o must equal ~a from two edges earlier
  task automatic test_inverter_stream();
    logic [1:0] d1, d2, d3, nv;
    logic b;
    en_a = 2'b11;
    d1 = a_a; d2 = a_a; d3 = a_a;
    for (int cyc = 0; cyc < 90; cyc++) begin
      tick();
      if (cyc >= 2) begin
        total++;
        if (o_a !== ~d2) begin bad++; $display("FAIL stream_o cyc=%0d: got %b want %b", cyc, o_a, ~d2); end
      end
      if (cyc >= 3) begin
        total++;
        if (ch_a !== (d2 ^ d3)) begin bad++; $display("FAIL stream_ch cyc=%0d: got %b want %b", cyc, ch_a, d2 ^ d3); end
      end
      d3 = d2; d2 = d1;
      b  = cyc[0];
      nv = {~b, b};
      a_a = nv;
      d1 = nv;
    end
  endtask

  task automatic test_load();
    a_a = 2'b00;
    tick(); tick(); tick();
    total++; if (o_a !== 2'b11) begin bad++; $display("FAIL load_pre_o: got %b want 11", o_a); end
    load_a = 1'b1; lv_a = 2'b10; en_a = 2'b11;
    tick();
    total++; if (o_a !== 2'b10) begin bad++; $display("FAIL load_o: got %b want 10", o_a); end
    total++; if (ch_a !== 2'b01) begin bad++; $display("FAIL load_ch: got %b want 01", ch_a); end
    load_a = 1'b0;
    tick();
    total++; if (o_a !== 2'b11) begin bad++; $display("FAIL load_after_o: got %b want 11", o_a); end
    total++; if (ch_a !== 2'b01) begin bad++; $display("FAIL load_after_ch: got %b want 01", ch_a); end
    tick();
    total++; if (ch_a !== 2'b00) begin bad++; $display("FAIL load_settle_ch: got %b want 00", ch_a); end
  endtask

  // en[1]=0 for 20 cycles while a[1] toggles; channel 0 keeps inverting
  task automatic test_freeze();
    logic [1:0] d1, d2, nv;
    logic b;
    d1 = a_a; d2 = a_a;
    en_a = 2'b01;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (o_a[1] !== 1'b1) begin bad++; $display("FAIL freeze_o1 i=%0d: got %b want 1", i, o_a[1]); end
      total++; if (ch_a[1] !== 1'b0) begin bad++; $display("FAIL freeze_ch1 i=%0d: got %b want 0", i, ch_a[1]); end
      if (i >= 2) begin
        total++;
        if (o_a[0] !== ~d2[0]) begin bad++; $display("FAIL freeze_o0 i=%0d: got %b want %b", i, o_a[0], ~d2[0]); end
      end
      d2 = d1;
      b  = i[0];
      nv = {b, ~b};
      a_a = nv;
      d1 = nv;
    end
    // the last drive left a[1]=1; hold it and re-enable channel 1
    en_a = 2'b11;
    tick();
    total++; if (o_a[1] !== 1'b1) begin bad++; $display("FAIL reen_e1_o1: got %b want 1", o_a[1]); end
    total++; if (ch_a[1] !== 1'b0) begin bad++; $display("FAIL reen_e1_ch1: got %b want 0", ch_a[1]); end
    tick();
    total++; if (o_a[1] !== 1'b0) begin bad++; $display("FAIL reen_e2_o1: got %b want 0", o_a[1]); end
    total++; if (ch_a[1] !== 1'b1) begin bad++; $display("FAIL reen_e2_ch1: got %b want 1", ch_a[1]); end
    for (int j = 0; j < 2; j++) begin
      tick();
      total++; if (o_a[1] !== 1'b0) begin bad++; $display("FAIL reen_hold_o1 j=%0d: got %b want 0", j, o_a[1]); end
      total++; if (ch_a[1] !== 1'b0) begin bad++; $display("FAIL reen_hold_ch1 j=%0d: got %b want 0", j, ch_a[1]); end
    end
  endtask

  // TABLE 8'hD2: four rising edges on a[0] produce four toggles
  task automatic test_toggle();
    logic exp_o;
    logic exp_ch;
    int   pulses;
    exp_o = 1'b0;
    pulses = 0;
    en_t = 2'b01;
    for (int t = 0; t < 20; t++) begin
      if (t < 16) a_t[0] = ((t % 4) < 2);
      tick();
      exp_ch = ((t % 4) == 1) && (t < 16);
      if (exp_ch) exp_o = ~exp_o;
      if (ch_t[0] === 1'b1) pulses++;
      total++; if (o_t[0] !== exp_o) begin bad++; $display("FAIL toggle_o t=%0d: got %b want %b", t, o_t[0], exp_o); end
      total++; if (ch_t[0] !== exp_ch) begin bad++; $display("FAIL toggle_ch t=%0d: got %b want %b", t, ch_t[0], exp_ch); end
    end
    total++; if (pulses !== 4) begin bad++; $display("FAIL toggle_pulses: got %0d want 4", pulses); end
    total++; if (o_t[0] !== 1'b0) begin bad++; $display("FAIL toggle_final_o: got %b want 0", o_t[0]); end
  endtask

  // a[1] goes high while channel 1 is disabled; enabling it later must not toggle
  task automatic test_no_spurious_edge();
    en_t = 2'b01;
    a_t[1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    en_t = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (o_t[1] !== 1'b0) begin bad++; $display("FAIL nospur_o1 i=%0d: got %b want 0", i, o_t[1]); end
      total++; if (ch_t[1] !== 1'b0) begin bad++; $display("FAIL nospur_ch1 i=%0d: got %b want 0", i, ch_t[1]); end
    end
    a_t[1] = 1'b0;
    tick(); tick();
    a_t[1] = 1'b1;
    tick(); tick();
    total++; if (o_t[1] !== 1'b1) begin bad++; $display("FAIL rise_after_en_o1: got %b want 1", o_t[1]); end
    total++; if (ch_t[1] !== 1'b1) begin bad++; $display("FAIL rise_after_en_ch1: got %b want 1", ch_t[1]); end
  endtask

  // FILTER=4: a 3-sample pulse is rejected; a held level lands 4 edges later
  task automatic test_filter();
    logic exp_o;
    logic exp_ch;
    en_f = 2'b11;
    a_f[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (o_f[0] !== 1'b1) begin bad++; $display("FAIL glitch_o0 i=%0d: got %b want 1", i, o_f[0]); end
    end
    a_f[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (o_f[0] !== 1'b1) begin bad++; $display("FAIL glitch_after_o0 i=%0d: got %b want 1", i, o_f[0]); end
      total++; if (ch_f[0] !== 1'b0) begin bad++; $display("FAIL glitch_after_ch0 i=%0d: got %b want 0", i, ch_f[0]); end
    end
    a_f[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_o  = (k >= 5) ? 1'b0 : 1'b1;
      exp_ch = (k == 5);
      total++; if (o_f[0] !== exp_o) begin bad++; $display("FAIL filt_o0 k=%0d: got %b want %b", k, o_f[0], exp_o); end
      total++; if (ch_f[0] !== exp_ch) begin bad++; $display("FAIL filt_ch0 k=%0d: got %b want %b", k, ch_f[0], exp_ch); end
    end
  endtask

  // reset between edges while changed is high and a filter count is pending
  task automatic test_reset_mid();
    a_f = 2'b11;
    for (int k = 1; k <= 5; k++) tick();
    total++; if (o_f !== 2'b00) begin bad++; $display("FAIL pre_rst_o: got %b want 00", o_f); end
    total++; if (ch_f !== 2'b10) begin bad++; $display("FAIL pre_rst_ch: got %b want 10", ch_f); end
    a_f = 2'b00;
    #2;
    rst_f = 1'b1;
    #1;
    total++; if (o_f !== 2'b11) begin bad++; $display("FAIL mid_rst_o: got %b want 11", o_f); end
    total++; if (ch_f !== 2'b00) begin bad++; $display("FAIL mid_rst_ch: got %b want 00", ch_f); end
    tick();
    rst_f = 1'b0;
    tick();
    a_f = 2'b11;
    tick(); tick();
    a_f = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (o_f !== 2'b11) begin bad++; $display("FAIL post_rst_o i=%0d: got %b want 11", i, o_f); end
      total++; if (ch_f !== 2'b00) begin bad++; $display("FAIL post_rst_ch i=%0d: got %b want 00", i, ch_f); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_a = 1'b0; rst_t = 1'b0; rst_f = 1'b0;
    en_a = 2'b11; a_a = 2'b00; load_a = 1'b0; lv_a = 2'b00;
    en_t = 2'b01; a_t = 2'b00; load_t = 1'b0; lv_t = 2'b00;
    en_f = 2'b11; a_f = 2'b00; load_f = 1'b0; lv_f = 2'b00;
    test_reset();
    test_inverter_stream();
    test_load();
    test_freeze();
    test_toggle();
    test_no_spurious_edge();
    test_filter();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
